// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: ALU and branch function encodings used by the
// decoder and by anything downstream that consumes its outputs.
// No logic, constants only.
package riscv_pkg;

  localparam logic [3:0] ALU_FUNC_ADD  = 4'd0;
  localparam logic [3:0] ALU_FUNC_SUB  = 4'd1;
  localparam logic [3:0] ALU_FUNC_SLL  = 4'd2;
  localparam logic [3:0] ALU_FUNC_SLT  = 4'd3;
  localparam logic [3:0] ALU_FUNC_SLTU = 4'd4;
  localparam logic [3:0] ALU_FUNC_XOR  = 4'd5;
  localparam logic [3:0] ALU_FUNC_SRL  = 4'd6;
  localparam logic [3:0] ALU_FUNC_SRA  = 4'd7;
  localparam logic [3:0] ALU_FUNC_OR   = 4'd8;
  localparam logic [3:0] ALU_FUNC_AND  = 4'd9;
  localparam logic [3:0] ALU_FUNC_LUI  = 4'd10;
  localparam logic [3:0] ALU_FUNC_JALR = 4'd11;
  localparam logic [3:0] ALU_FUNC_BR   = 4'd12;

  localparam logic [2:0] BR_FUNC_EQ  = 3'd0;
  localparam logic [2:0] BR_FUNC_NE  = 3'd1;
  localparam logic [2:0] BR_FUNC_LT  = 3'd2;
  localparam logic [2:0] BR_FUNC_GE  = 3'd3;
  localparam logic [2:0] BR_FUNC_LTU = 3'd4;
  localparam logic [2:0] BR_FUNC_GEU = 3'd5;

endpackage

// File: rtl/riscv_decode.sv
// RV32I instruction decoder with a one-deep registered output stage.
// Latency: 1 cycle from acceptance to outputs.
// Backpressure: inst_ready_out = !dec_valid_out || !stall_in; stall holds the
// output register, flush clears it and drops the instruction offered that cycle.
// Ports: clk_in/rst_in (sync active-high); inst_valid_in/inst_in/pc_in/
// inst_ready_out from fetch; stall_in/flush_in from execute; dec_*_out,
// alu/br func, register indices, immediate, operand selects, write/memory
// enables, memory size, branch/jump flags and illegal flag toward execute.
module riscv_decode #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        inst_valid_in,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_in,
  output logic        inst_ready_out,
  input  logic        stall_in,
  input  logic        flush_in,
  output logic        dec_valid_out,
  output logic [31:0] dec_pc_out,
  output logic [3:0]  alu_func_out,
  output logic [2:0]  br_func_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [4:0]  rd_out,
  output logic [31:0] imm_out,
  output logic        a_sel_out,
  output logic        b_sel_out,
  output logic        rf_we_out,
  output logic        mem_re_out,
  output logic        mem_we_out,
  output logic [2:0]  mem_size_out,
  output logic        is_branch_out,
  output logic        is_jump_out,
  output logic        illegal_out
);
  import riscv_pkg::*;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic [3:0]  alu_func;
    logic [2:0]  br_func;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        a_sel;
    logic        b_sel;
    logic        rf_we;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
  } dec_t;

  // Register-register / register-immediate ALU op from funct3; alt selects
  // SUB/SRA (inst[30]) where the caller has already qualified it.
  function automatic logic [3:0] alu_of_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] f;
    case (f3)
      3'b000:  f = alt ? ALU_FUNC_SUB : ALU_FUNC_ADD;
      3'b001:  f = ALU_FUNC_SLL;
      3'b010:  f = ALU_FUNC_SLT;
      3'b011:  f = ALU_FUNC_SLTU;
      3'b100:  f = ALU_FUNC_XOR;
      3'b101:  f = alt ? ALU_FUNC_SRA : ALU_FUNC_SRL;
      3'b110:  f = ALU_FUNC_OR;
      default: f = ALU_FUNC_AND;
    endcase
    return f;
  endfunction

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t        d;
    logic        ok;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    f7    = inst[31:25];
    f3    = inst[14:12];
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u = {inst[31:12], 12'b0};
    imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    d          = '0;
    d.alu_func = ALU_FUNC_ADD;
    d.br_func  = BR_FUNC_EQ;
    d.rs1      = inst[19:15];
    d.rs2      = inst[24:20];
    d.rd       = inst[11:7];
    d.mem_size = f3;
    ok         = 1'b1;

    // Opcode compare covers inst[1:0]==11 too; anything else lands in default.
    case (inst[6:0])
      OPC_OP: begin
        ok = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
        d.alu_func = alu_of_funct3(f3, f7[5]);
        d.rf_we    = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only the shift forms constrain inst[31:25]; elsewhere it is immediate.
        if (f3 == 3'b001)      ok = (f7 == 7'h00);
        else if (f3 == 3'b101) ok = (f7 == 7'h00) || (f7 == 7'h20);
        d.alu_func = alu_of_funct3(f3, (f3 == 3'b101) && f7[5]);
        d.b_sel    = 1'b1;
        d.imm      = imm_i;
        d.rf_we    = 1'b1;
      end
      OPC_LUI: begin
        d.alu_func = ALU_FUNC_LUI;
        d.b_sel    = 1'b1;
        d.imm      = imm_u;
        d.rf_we    = 1'b1;
      end
      OPC_AUIPC: begin
        d.a_sel = 1'b1;
        d.b_sel = 1'b1;
        d.imm   = imm_u;
        d.rf_we = 1'b1;
      end
      OPC_JAL: begin
        d.a_sel   = 1'b1;
        d.b_sel   = 1'b1;
        d.imm     = imm_j;
        d.is_jump = 1'b1;
        d.rf_we   = 1'b1;
      end
      OPC_JALR: begin
        ok         = (f3 == 3'b000);
        d.alu_func = ALU_FUNC_JALR;
        d.b_sel    = 1'b1;
        d.imm      = imm_i;
        d.is_jump  = 1'b1;
        d.rf_we    = 1'b1;
      end
      OPC_BRANCH: begin
        d.alu_func  = ALU_FUNC_BR;
        d.imm       = imm_b;
        d.is_branch = 1'b1;
        case (f3)
          3'b000:  d.br_func = BR_FUNC_EQ;
          3'b001:  d.br_func = BR_FUNC_NE;
          3'b100:  d.br_func = BR_FUNC_LT;
          3'b101:  d.br_func = BR_FUNC_GE;
          3'b110:  d.br_func = BR_FUNC_LTU;
          3'b111:  d.br_func = BR_FUNC_GEU;
          default: ok = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        ok       = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                   (f3 == 3'b100) || (f3 == 3'b101);
        d.b_sel  = 1'b1;
        d.imm    = imm_i;
        d.mem_re = 1'b1;
        d.rf_we  = 1'b1;
      end
      OPC_STORE: begin
        ok       = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        d.b_sel  = 1'b1;
        d.imm    = imm_s;
        d.mem_we = 1'b1;
      end
      default: ok = 1'b0;
    endcase

    if (d.rd == 5'd0) d.rf_we = 1'b0;

    // Illegal instructions travel down the pipe as a harmless ADD with every
    // side-effect enable cleared; execute raises the exception from the flag.
    if (!ok) begin
      d.illegal   = 1'b1;
      d.alu_func  = ALU_FUNC_ADD;
      d.br_func   = BR_FUNC_EQ;
      d.imm       = '0;
      d.a_sel     = 1'b0;
      d.b_sel     = 1'b0;
      d.rf_we     = 1'b0;
      d.mem_re    = 1'b0;
      d.mem_we    = 1'b0;
      d.is_branch = 1'b0;
      d.is_jump   = 1'b0;
    end
    return d;
  endfunction

  dec_t        in_dec;
  dec_t        nop_dec;
  dec_t        dec_q;
  logic        valid_q;
  logic [31:0] pc_q;
  logic        accept;

  assign in_dec  = decode(inst_in);
  assign nop_dec = decode(NOP_INSTR);

  assign inst_ready_out = !valid_q || !stall_in;
  assign accept         = inst_valid_in && inst_ready_out && !flush_in;

  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      dec_q   <= nop_dec;
    end else if (!(valid_q && stall_in)) begin
      if (accept) begin
        valid_q <= 1'b1;
        pc_q    <= pc_in;
        dec_q   <= in_dec;
      end else begin
        valid_q <= 1'b0;
        pc_q    <= '0;
        dec_q   <= nop_dec;
      end
    end
  end

  assign dec_valid_out = valid_q;
  assign dec_pc_out    = pc_q;
  assign alu_func_out  = dec_q.alu_func;
  assign br_func_out   = dec_q.br_func;
  assign rs1_out       = dec_q.rs1;
  assign rs2_out       = dec_q.rs2;
  assign rd_out        = dec_q.rd;
  assign imm_out       = dec_q.imm;
  assign a_sel_out     = dec_q.a_sel;
  assign b_sel_out     = dec_q.b_sel;
  assign rf_we_out     = dec_q.rf_we;
  assign mem_re_out    = dec_q.mem_re;
  assign mem_we_out    = dec_q.mem_we;
  assign mem_size_out  = dec_q.mem_size;
  assign is_branch_out = dec_q.is_branch;
  assign is_jump_out   = dec_q.is_jump;
  assign illegal_out   = dec_q.illegal;

endmodule

// File: tb/tb_riscv_decode.sv
// Self-checking bench for riscv_decode: directed cases plus randomized
// instruction/handshake traffic against a behavioural decode + pipe model.
module tb_riscv_decode;
  import riscv_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        inst_valid_in;
  logic [31:0] inst_in;
  logic [31:0] pc_in;
  logic        inst_ready_out;
  logic        stall_in;
  logic        flush_in;
  logic        dec_valid_out;
  logic [31:0] dec_pc_out;
  logic [3:0]  alu_func_out;
  logic [2:0]  br_func_out;
  logic [4:0]  rs1_out;
  logic [4:0]  rs2_out;
  logic [4:0]  rd_out;
  logic [31:0] imm_out;
  logic        a_sel_out;
  logic        b_sel_out;
  logic        rf_we_out;
  logic        mem_re_out;
  logic        mem_we_out;
  logic [2:0]  mem_size_out;
  logic        is_branch_out;
  logic        is_jump_out;
  logic        illegal_out;

  riscv_decode dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .inst_valid_in(inst_valid_in), .inst_in(inst_in), .pc_in(pc_in),
    .inst_ready_out(inst_ready_out), .stall_in(stall_in), .flush_in(flush_in),
    .dec_valid_out(dec_valid_out), .dec_pc_out(dec_pc_out),
    .alu_func_out(alu_func_out), .br_func_out(br_func_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out), .imm_out(imm_out),
    .a_sel_out(a_sel_out), .b_sel_out(b_sel_out), .rf_we_out(rf_we_out),
    .mem_re_out(mem_re_out), .mem_we_out(mem_we_out), .mem_size_out(mem_size_out),
    .is_branch_out(is_branch_out), .is_jump_out(is_jump_out), .illegal_out(illegal_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0]  alu;
    logic [2:0]  br;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        a_sel;
    logic        b_sel;
    logic        rf_we;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
  } ref_t;

  int   n_cmp;
  int   n_err;
  logic m_valid;
  logic [31:0] m_pc;
  ref_t m_d;
  ref_t nop_ref;
  logic [3:0] alu_tab [8];
  logic [2:0] br_tab  [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  // Sign-extend the low 'bits' of v using arithmetic shifts on a signed int.
  function automatic logic [31:0] sx(input int v, input int bits);
    int t;
    t = v <<< (32 - bits);
    t = t >>> (32 - bits);
    return t;
  endfunction

  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t r;
    int   op;
    int   f3;
    int   f7;
    bit   legal;
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    r = '0;
    r.rs1 = w[19:15];
    r.rs2 = w[24:20];
    r.rd  = w[11:7];
    r.mem_size = w[14:12];
    r.alu = ALU_FUNC_ADD;
    legal = 1'b1;
    if (op == 'h33) begin
      legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      r.alu = alu_tab[f3];
      if (f7 == 32 && f3 == 0) r.alu = ALU_FUNC_SUB;
      if (f7 == 32 && f3 == 5) r.alu = ALU_FUNC_SRA;
      r.rf_we = 1;
    end else if (op == 'h13) begin
      if (f3 == 1) legal = (f7 == 0);
      if (f3 == 5) legal = (f7 == 0) || (f7 == 32);
      r.alu = alu_tab[f3];
      if (f3 == 5 && f7 == 32) r.alu = ALU_FUNC_SRA;
      r.b_sel = 1; r.imm = sx(int'(w[31:20]), 12); r.rf_we = 1;
    end else if (op == 'h37) begin
      r.alu = ALU_FUNC_LUI; r.b_sel = 1; r.imm = int'(w[31:12]) * 4096; r.rf_we = 1;
    end else if (op == 'h17) begin
      r.a_sel = 1; r.b_sel = 1; r.imm = int'(w[31:12]) * 4096; r.rf_we = 1;
    end else if (op == 'h6f) begin
      r.a_sel = 1; r.b_sel = 1; r.is_jump = 1; r.rf_we = 1;
      r.imm = sx(int'(w[31]) * (1 << 20) + int'(w[19:12]) * 4096 +
                 int'(w[20]) * 2048 + int'(w[30:21]) * 2, 21);
    end else if (op == 'h67) begin
      legal = (f3 == 0);
      r.alu = ALU_FUNC_JALR; r.b_sel = 1; r.imm = sx(int'(w[31:20]), 12);
      r.is_jump = 1; r.rf_we = 1;
    end else if (op == 'h63) begin
      legal = (f3 != 2 && f3 != 3);
      r.alu = ALU_FUNC_BR; r.br = br_tab[f3]; r.is_branch = 1;
      r.imm = sx(int'(w[31]) * 4096 + int'(w[7]) * 2048 +
                 int'(w[30:25]) * 32 + int'(w[11:8]) * 2, 13);
    end else if (op == 'h03) begin
      legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      r.b_sel = 1; r.imm = sx(int'(w[31:20]), 12); r.mem_re = 1; r.rf_we = 1;
    end else if (op == 'h23) begin
      legal = (f3 <= 2);
      r.b_sel = 1; r.imm = sx(int'(w[31:25]) * 32 + int'(w[11:7]), 12); r.mem_we = 1;
    end else begin
      legal = 1'b0;
    end
    if (r.rd == 0) r.rf_we = 0;
    if (!legal) begin
      r.illegal = 1; r.alu = ALU_FUNC_ADD;
      r.rf_we = 0; r.mem_re = 0; r.mem_we = 0; r.is_branch = 0; r.is_jump = 0;
    end
    return r;
  endfunction

  task automatic compare_outputs();
    chk("valid", dec_valid_out, m_valid);
    if (m_valid) begin
      chk("pc", dec_pc_out, m_pc);
      chk("illegal", illegal_out, m_d.illegal);
      chk("alu", alu_func_out, m_d.alu);
      chk("rs1", rs1_out, m_d.rs1);
      chk("rs2", rs2_out, m_d.rs2);
      chk("rd", rd_out, m_d.rd);
      chk("rf_we", rf_we_out, m_d.rf_we);
      chk("mem_re", mem_re_out, m_d.mem_re);
      chk("mem_we", mem_we_out, m_d.mem_we);
      chk("mem_size", mem_size_out, m_d.mem_size);
      chk("is_branch", is_branch_out, m_d.is_branch);
      chk("is_jump", is_jump_out, m_d.is_jump);
      if (!m_d.illegal) begin
        chk("imm", imm_out, m_d.imm);
        chk("a_sel", a_sel_out, m_d.a_sel);
        chk("b_sel", b_sel_out, m_d.b_sel);
        if (m_d.is_branch) chk("br_func", br_func_out, m_d.br);
      end
    end else begin
      chk("idle_illegal", illegal_out, 1'b0);
      chk("idle_alu", alu_func_out, ALU_FUNC_ADD);
      chk("idle_rf_we", rf_we_out, 1'b0);
      chk("idle_mem_re", mem_re_out, 1'b0);
      chk("idle_mem_we", mem_we_out, 1'b0);
      chk("idle_branch", is_branch_out, 1'b0);
      chk("idle_jump", is_jump_out, 1'b0);
    end
  endtask

  // Drive one cycle of inputs, check ready, advance the model, clock, check outputs.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic st, input logic fl, input logic rs);
    logic exp_rdy;
    logic acc;
    inst_valid_in = v; inst_in = ins; pc_in = pc;
    stall_in = st; flush_in = fl; rst_in = rs;
    #1;
    exp_rdy = !m_valid || !st;
    chk("ready", inst_ready_out, exp_rdy);
    acc = v && exp_rdy && !fl;
    if (rs || fl) begin
      m_valid = 0; m_pc = 0; m_d = nop_ref;
    end else if (m_valid && st) begin
      // output register frozen
    end else if (acc) begin
      m_valid = 1; m_pc = pc; m_d = ref_decode(ins);
    end else begin
      m_valid = 0; m_pc = 0; m_d = nop_ref;
    end
    @(posedge clk_in);
    #1;
    compare_outputs();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 10);
    case (k)
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h37;
      3: w[6:0] = 7'h17;
      4: w[6:0] = 7'h6f;
      5: w[6:0] = 7'h67;
      6: w[6:0] = 7'h63;
      7: w[6:0] = 7'h03;
      8: w[6:0] = 7'h23;
      9: w[1:0] = 2'($urandom_range(0, 2));
      default: ;
    endcase
    if (k <= 1 && $urandom_range(0, 3) != 0)
      w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if (k == 5 && $urandom_range(0, 1) == 1) w[14:12] = 3'b000;
    return w;
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    alu_tab[0] = ALU_FUNC_ADD; alu_tab[1] = ALU_FUNC_SLL;
    alu_tab[2] = ALU_FUNC_SLT; alu_tab[3] = ALU_FUNC_SLTU;
    alu_tab[4] = ALU_FUNC_XOR; alu_tab[5] = ALU_FUNC_SRL;
    alu_tab[6] = ALU_FUNC_OR;  alu_tab[7] = ALU_FUNC_AND;
    br_tab[0] = BR_FUNC_EQ;  br_tab[1] = BR_FUNC_NE;
    br_tab[2] = BR_FUNC_EQ;  br_tab[3] = BR_FUNC_EQ;
    br_tab[4] = BR_FUNC_LT;  br_tab[5] = BR_FUNC_GE;
    br_tab[6] = BR_FUNC_LTU; br_tab[7] = BR_FUNC_GEU;
    nop_ref = ref_decode(32'h00000013);

    inst_valid_in = 1; inst_in = 32'h002081B3; pc_in = 32'h44;
    stall_in = 0; flush_in = 0; rst_in = 1;
    m_valid = 0; m_pc = 0; m_d = nop_ref;
    repeat (2) @(posedge clk_in);
    #1;
    // Reset state, with an instruction offered during reset
    chk("rst_valid", dec_valid_out, 1'b0);
    chk("rst_ready", inst_ready_out, 1'b1);
    chk("rst_pc", dec_pc_out, 32'h0);
    chk("rst_illegal", illegal_out, 1'b0);
    chk("rst_rd", rd_out, 5'd0);
    compare_outputs();

    // Basic R-type, SUB, branch, LUI, all-zero illegal
    step(1, 32'h002081B3, 32'h100, 0, 0, 0);
    chk("add_alu", alu_func_out, ALU_FUNC_ADD);
    chk("add_rd", rd_out, 5'd3);
    chk("add_pc", dec_pc_out, 32'h100);
    chk("add_rf_we", rf_we_out, 1'b1);
    step(1, 32'h407302B3, 32'h104, 0, 0, 0);
    chk("sub_alu", alu_func_out, ALU_FUNC_SUB);
    chk("sub_rd", rd_out, 5'd5);
    step(1, 32'hFE000EE3, 32'h108, 0, 0, 0);
    chk("beq_alu", alu_func_out, ALU_FUNC_BR);
    chk("beq_br", br_func_out, BR_FUNC_EQ);
    chk("beq_imm", imm_out, 32'hFFFFFFFC);
    chk("beq_is_branch", is_branch_out, 1'b1);
    chk("beq_rf_we", rf_we_out, 1'b0);
    step(1, 32'h123450B7, 32'h10C, 0, 0, 0);
    chk("lui_alu", alu_func_out, ALU_FUNC_LUI);
    chk("lui_imm", imm_out, 32'h12345000);
    chk("lui_b_sel", b_sel_out, 1'b1);
    step(1, 32'h00000000, 32'h110, 0, 0, 0);
    chk("zero_illegal", illegal_out, 1'b1);
    chk("zero_valid", dec_valid_out, 1'b1);

    // Stall for three cycles with new instructions offered: frozen outputs
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h002081B3, 32'h200 + 32'(i), 1, 0, 0);
      chk("stall_frozen_illegal", illegal_out, 1'b1);
      chk("stall_frozen_pc", dec_pc_out, 32'h110);
      chk("stall_ready", inst_ready_out, 1'b0);
    end
    step(1, 32'h123450B7, 32'h300, 0, 0, 0);
    chk("unstall_rd", rd_out, 5'd1);
    chk("unstall_pc", dec_pc_out, 32'h300);

    // Flush while stalled with a valid input: register cleared, input dropped
    step(1, 32'h002081B3, 32'h400, 1, 1, 0);
    chk("flush_valid", dec_valid_out, 1'b0);
    step(0, 32'h0, 32'h0, 0, 0, 0);
    chk("flush_dropped", dec_valid_out, 1'b0);

    // Reset in the middle of a stall
    step(1, 32'h00C58533, 32'h500, 0, 0, 0);
    step(1, 32'h002081B3, 32'h504, 1, 0, 0);
    step(1, 32'h002081B3, 32'h508, 1, 0, 1);
    chk("rst_stall_valid", dec_valid_out, 1'b0);
    chk("rst_stall_ready", inst_ready_out, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), rand_inst(), $urandom,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_decode.md
RISCV_DECODE -- requirements
Module: riscv_decode

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h00000013, the instruction whose decode is held in the output register while invalid.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have port clk_in, input, 1, the clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, the synchronous active-high reset.
REQ-005 SHALL have port inst_valid_in, input, 1, fetch presents an instruction.
REQ-006 SHALL have port inst_in, input, 32, instruction word.
REQ-007 SHALL have port pc_in, input, 32, PC of inst_in.
REQ-008 SHALL have port inst_ready_out, output, 1, decode can accept this cycle.
REQ-009 SHALL have port stall_in, input, 1, execute cannot consume the output register.
REQ-010 SHALL have port flush_in, input, 1, kill the held and the incoming instruction.
REQ-011 SHALL have port dec_valid_out, output, 1, output register holds a live instruction.
REQ-012 SHALL have the following output ports:
- dec_pc_out (32): PC.
- alu_func_out (4): ALU_FUNC_* code.
- br_func_out (3): BR_FUNC_* code.
- rs1_out, rs2_out, rd_out (5 each): register indices.
- imm_out (32): sign-extended immediate.
- a_sel_out (1): 0=rs1, 1=PC.
- b_sel_out (1): 0=rs2, 1=imm.
- rf_we_out (1): register-file write enable.
- mem_re_out, mem_we_out (1 each): memory read/write.
- mem_size_out (3): funct3.
- is_branch_out, is_jump_out (1 each): branch/jump flags.
- illegal_out (1): illegal-instruction flag.
REQ-013 SHALL take ALU_FUNC_* and BR_FUNC_* encodings from the shared riscv constants header.

Function
REQ-014 SHALL have a one-deep registered output stage, so an accepted instruction is visible on the outputs one cycle after acceptance.
REQ-015 SHALL drive inst_ready_out = !dec_valid_out || !stall_in, combinationally.
REQ-016 SHALL treat an instruction as accepted when inst_valid_in && inst_ready_out && !flush_in; on acceptance the register loads the decode and sets dec_valid_out=1.
REQ-017 SHALL clear dec_valid_out and load the NOP_INSTR decode when there is no acceptance and stall_in=0.
REQ-018 SHALL hold every output unchanged while dec_valid_out=1 and stall_in=1.
REQ-019 SHALL give flush_in priority over stall and acceptance: next cycle dec_valid_out=0, and an instruction offered in the flush cycle is dropped (upstream sees the handshake complete).
REQ-020 SHALL take rs1/rs2/rd from inst[19:15]/[24:20]/[11:7] for all formats, with rf_we_out=0 whenever rd=0.
REQ-021 SHALL form immediates as follows, with imm_out=0 for R-type:
- I: sext(inst[31:20]).
- S: sext({inst[31:25],inst[11:7]}).
- B: sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
- U: {inst[31:12],12'b0}.
- J: sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
REQ-022 SHALL decode OP (0110011), with funct7 0000000 or 0100000 (the latter only for ADD→SUB and SRL→SRA), mapping funct3 to ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND, with a_sel=0, b_sel=0, rf_we=1.
REQ-023 SHALL decode OP-IMM (0010011) with the same mapping except no SUB; for SLLI/SRLI/SRAI, inst[31:25] SHALL be 0000000, or 0100000 (SRAI only); b_sel=1.
REQ-024 SHALL decode LUI as ALU_FUNC_LUI, b_sel=1, U-imm; AUIPC as ADD, a_sel=1, b_sel=1, U-imm.
REQ-025 SHALL decode JAL as ADD, a_sel=1, b_sel=1, J-imm, is_jump=1; JALR (funct3=000) as ALU_FUNC_JALR, b_sel=1, I-imm, is_jump=1; both with rf_we=1.
REQ-026 SHALL decode BRANCH as ALU_FUNC_BR, br_func per funct3 (EQ, NE, LT, GE, LTU, GEU), B-imm, is_branch=1, rf_we=0; funct3 010/011 is illegal.
REQ-027 SHALL decode LOAD as ADD, b_sel=1, I-imm, mem_re=1, rf_we=1, with funct3 in {000,001,010,100,101}.
REQ-028 SHALL decode STORE as ADD, b_sel=1, S-imm, mem_we=1, with funct3 in {000,001,010}.
REQ-029 SHALL treat any other opcode, inst[1:0]!=11, or a disallowed funct field as illegal: illegal_out=1, dec_valid_out=1, alu_func=ADD, with rf_we, mem_re, mem_we, is_branch and is_jump all 0.
REQ-030 SHALL drive mem_size_out=inst[14:12] for every instruction.

Reset
REQ-031 SHALL, when rst_in=1 at a clock edge (including with a held or incoming instruction), set dec_valid_out=0, illegal_out=0, dec_pc_out=0 and load the NOP_INSTR decode (ADD, rd=0, rf_we=0), dropping any input.
REQ-032 SHALL drive inst_ready_out=1 in the first cycle after reset.

Verification
REQ-033 SHALL cover: 0x002081B3 at pc 0x100 → next cycle valid, rs1=1, rs2=2, rd=3, ADD, rf_we=1, dec_pc=0x100; and 0x407302B3 → SUB, rd=5.
REQ-034 SHALL cover: 0xFE000EE3 → ALU_FUNC_BR, BR_FUNC_EQ, imm=0xFFFFFFFC, is_branch=1, rf_we=0.
REQ-035 SHALL cover: 0x123450B7 → ALU_FUNC_LUI, b_sel=1, imm=0x12345000, rd=1; and 0x00000000 → illegal_out=1, all enables 0.
REQ-036 SHALL cover: valid output with stall_in=1 for 3 cycles → outputs frozen, inst_ready_out=0; stall drops → next instruction loads.
REQ-037 SHALL cover: flush_in with stall_in=1 and valid input → next cycle dec_valid_out=0 and input dropped; rst_in mid-stall → dec_valid_out=0, inst_ready_out=1.
